// File: rtl/threebitcounter_driver_if.sv
// Command and counter-drive bundle between a command source and the three-bit counter driver.
// The slave modport is the driver's view; master is the view of whoever sources commands and returns data_out.
interface threebitcounter_driver_if;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic [2:0] cmd_data;
  logic [3:0] cmd_len;
  logic       cmd_ready;
  logic       ld;
  logic       inc;
  logic [2:0] data_in;
  logic [2:0] data_out;
  logic [2:0] model;
  logic       busy;
  logic       blocked;
  logic       mismatch;
  logic [7:0] err_count;

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_len, data_out,
    output cmd_ready, ld, inc, data_in, model, busy, blocked, mismatch, err_count
  );

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_len, data_out,
    input  cmd_ready, ld, inc, data_in, model, busy, blocked, mismatch, err_count
  );
endinterface

// File: rtl/threebitcounter_driver.sv
// Drives ld/inc strobes into a three-bit counter from HOLD/LOAD/INC/CLEAR commands, tracks a reference
// model of the counter, refuses increments that would wrap 7->0, and counts data_out/model disagreements.
module threebitcounter_driver (
  input logic                          clk,
  input logic                          rst,
  threebitcounter_driver_if.slave      bus
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [1:0] OP_HOLD  = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_INC   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       is_inc_q, is_inc_d;
  logic       ld_q, ld_d;
  logic       inc_q, inc_d;
  logic [2:0] data_in_q, data_in_d;
  logic       blocked_q, blocked_d;
  logic [2:0] model_q, model_d;
  logic       armed_q;
  logic       mismatch_q, mismatch_d;
  logic [7:0] err_q, err_d;
  logic [2:0] p;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_inc_d  = is_inc_q;
    ld_d      = 1'b0;
    inc_d     = 1'b0;
    data_in_d = 3'd0;
    blocked_d = 1'b0;
    // Counter value the next strobe would act on; reaching 7 means a further inc would wrap.
    p         = model_q + {2'b00, inc_q};
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          state_d  = RUN;
          cnt_d    = bus.cmd_len;
          is_inc_d = (bus.cmd_op == OP_INC);
          case (bus.cmd_op)
            OP_LOAD: begin
              ld_d      = 1'b1;
              data_in_d = bus.cmd_data;
              cnt_d     = 4'd0;
            end
            OP_CLEAR: begin
              ld_d  = 1'b1;
              cnt_d = 4'd0;
            end
            OP_INC: begin
              if (p == 3'd7) begin
                blocked_d = 1'b1;
                state_d   = IDLE;
              end else begin
                inc_d = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      RUN: begin
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (is_inc_q) begin
            if (p == 3'd7) begin
              blocked_d = 1'b1;
              state_d   = IDLE;
            end else begin
              inc_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready = (state_q == IDLE);
    bus.busy      = (state_q == RUN);
    bus.ld        = ld_q;
    bus.inc       = inc_q;
    bus.data_in   = data_in_q;
    bus.model     = model_q;
    bus.blocked   = blocked_q;
    bus.mismatch  = mismatch_q;
    bus.err_count = err_q;
  end

  always_comb begin
    model_d = model_q;
    if (ld_q) begin
      model_d = data_in_q;
    end else if (inc_q) begin
      model_d = model_q + 3'd1;
    end
    // armed_q stays low for the first cycle after reset release so a settling counter is not flagged.
    mismatch_d = armed_q && (bus.data_out != model_q);
    err_d      = err_q;
    if (mismatch_d && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= 4'd0;
      is_inc_q   <= 1'b0;
      ld_q       <= 1'b0;
      inc_q      <= 1'b0;
      data_in_q  <= 3'd0;
      blocked_q  <= 1'b0;
      model_q    <= 3'd0;
      armed_q    <= 1'b0;
      mismatch_q <= 1'b0;
      err_q      <= 8'd0;
    end else begin
      cnt_q      <= cnt_d;
      is_inc_q   <= is_inc_d;
      ld_q       <= ld_d;
      inc_q      <= inc_d;
      data_in_q  <= data_in_d;
      blocked_q  <= blocked_d;
      model_q    <= model_d;
      armed_q    <= 1'b1;
      mismatch_q <= mismatch_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_threebitcounter_driver.sv
// Directed bench for threebitcounter_driver with a behavioural three-bit counter on the drive side
// whose returned value can be overridden to provoke disagreements.
module tb_threebitcounter_driver;

  logic clk;
  logic rst;
  logic force_en;
  logic [2:0] force_val;
  logic [2:0] stub_q;

  int n_cmp = 0;
  int n_err = 0;
  int inc_total = 0;
  int blk_total = 0;
  int mm_total = 0;
  int overlap_total = 0;

  threebitcounter_driver_if bus ();

  threebitcounter_driver dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      stub_q <= 3'd0;
    end else if (bus.ld) begin
      stub_q <= bus.data_in;
    end else if (bus.inc) begin
      stub_q <= stub_q + 3'd1;
    end
  end

  assign bus.data_out = force_en ? force_val : stub_q;

  // Tallies per-cycle events, sampled just after each edge so the whole cycle's value is seen.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      if (bus.inc === 1'b1) inc_total++;
      if (bus.blocked === 1'b1) blk_total++;
      if (bus.mismatch === 1'b1) mm_total++;
      if (bus.ld === 1'b1 && bus.inc === 1'b1) overlap_total++;
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [2:0] d, input logic [3:0] l);
    bus.cmd_valid = v;
    bus.cmd_op    = op;
    bus.cmd_data  = d;
    bus.cmd_len   = l;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ready"},   32'(bus.cmd_ready), 32'd1);
    chk({tag, "_busy"},    32'(bus.busy),      32'd0);
    chk({tag, "_ld"},      32'(bus.ld),        32'd0);
    chk({tag, "_inc"},     32'(bus.inc),       32'd0);
    chk({tag, "_data_in"}, 32'(bus.data_in),   32'd0);
    chk({tag, "_model"},   32'(bus.model),     32'd0);
    chk({tag, "_blocked"}, 32'(bus.blocked),   32'd0);
    chk({tag, "_mm"},      32'(bus.mismatch),  32'd0);
    chk({tag, "_err"},     32'(bus.err_count), 32'd0);
  endtask

  int base_inc;
  int base_blk;
  int base_mm;

  initial begin
    rst = 1'b1;
    force_en = 1'b0;
    force_val = 3'd0;
    drive(1'b0, 2'b00, 3'd0, 4'd0);
    step();
    step();
    chk_reset_state("rst");
    rst = 1'b0;
    step();

    // LOAD 5 then INC len 0
    drive(1'b1, 2'b01, 3'd5, 4'd0);
    step();
    drive(1'b0, 2'b00, 3'd0, 4'd0);
    chk("load5_ld", 32'(bus.ld), 32'd1);
    chk("load5_data_in", 32'(bus.data_in), 32'd5);
    chk("load5_busy", 32'(bus.busy), 32'd1);
    chk("load5_ready", 32'(bus.cmd_ready), 32'd0);
    step();
    chk("load5_model", 32'(bus.model), 32'd5);
    chk("load5_ready_back", 32'(bus.cmd_ready), 32'd1);
    drive(1'b1, 2'b10, 3'd0, 4'd0);
    step();
    drive(1'b0, 2'b00, 3'd0, 4'd0);
    chk("inc0_inc", 32'(bus.inc), 32'd1);
    chk("inc0_ld", 32'(bus.ld), 32'd0);
    step();
    chk("inc0_inc_done", 32'(bus.inc), 32'd0);
    chk("inc0_model", 32'(bus.model), 32'd6);
    chk("inc0_data_out", 32'(bus.data_out), 32'd6);
    chk("inc0_no_mm", 32'(mm_total), 32'd0);

    // CLEAR then INC len 15: guard stops after seven increments
    drive(1'b1, 2'b11, 3'd6, 4'd0);
    step();
    drive(1'b0, 2'b00, 3'd0, 4'd0);
    chk("clear_ld", 32'(bus.ld), 32'd1);
    chk("clear_data_in", 32'(bus.data_in), 32'd0);
    step();
    chk("clear_model", 32'(bus.model), 32'd0);
    base_inc = inc_total;
    base_blk = blk_total;
    drive(1'b1, 2'b10, 3'd0, 4'd15);
    step();
    drive(1'b0, 2'b00, 3'd0, 4'd0);
    for (int i = 0; i < 40; i++) begin
      if (bus.cmd_ready === 1'b1) break;
      step();
    end
    chk("inc15_ready_back", 32'(bus.cmd_ready), 32'd1);
    chk("inc15_blocked", 32'(bus.blocked), 32'd1);
    chk("inc15_inc_count", 32'(inc_total - base_inc), 32'd7);
    chk("inc15_model", 32'(bus.model), 32'd7);
    chk("inc15_data_out", 32'(bus.data_out), 32'd7);
    chk("inc15_err", 32'(bus.err_count), 32'd0);
    step();
    chk("inc15_blocked_once", 32'(blk_total - base_blk), 32'd1);
    chk("inc15_blocked_low", 32'(bus.blocked), 32'd0);

    // LOAD 7 then INC len 3: refused outright
    drive(1'b1, 2'b01, 3'd7, 4'd0);
    step();
    drive(1'b0, 2'b00, 3'd0, 4'd0);
    step();
    base_inc = inc_total;
    drive(1'b1, 2'b10, 3'd0, 4'd3);
    step();
    drive(1'b0, 2'b00, 3'd0, 4'd0);
    chk("at7_blocked", 32'(bus.blocked), 32'd1);
    chk("at7_inc", 32'(bus.inc), 32'd0);
    step();
    chk("at7_blocked_low", 32'(bus.blocked), 32'd0);
    chk("at7_model", 32'(bus.model), 32'd7);
    chk("at7_no_inc", 32'(inc_total - base_inc), 32'd0);

    // HOLD len 4 with cmd_valid held; a queued LOAD 3 waits for the IDLE cycle
    drive(1'b1, 2'b00, 3'd0, 4'd4);
    step();
    drive(1'b1, 2'b01, 3'd3, 4'd0);
    for (int i = 0; i < 5; i++) begin
      chk("hold_busy", 32'(bus.busy), 32'd1);
      chk("hold_ready", 32'(bus.cmd_ready), 32'd0);
      chk("hold_strobes", 32'({bus.ld, bus.inc}), 32'd0);
      step();
    end
    chk("hold_idle_busy", 32'(bus.busy), 32'd0);
    chk("hold_idle_ready", 32'(bus.cmd_ready), 32'd1);
    chk("hold_idle_ld", 32'(bus.ld), 32'd0);
    step();
    drive(1'b0, 2'b00, 3'd0, 4'd0);
    chk("hold_next_ld", 32'(bus.ld), 32'd1);
    chk("hold_next_data_in", 32'(bus.data_in), 32'd3);
    step();
    chk("hold_next_model", 32'(bus.model), 32'd3);
    chk("no_mm_so_far", 32'(mm_total), 32'd0);
    chk("no_overlap", 32'(overlap_total), 32'd0);

    // LOAD 2, then counter reports 3 for 300 cycles
    drive(1'b1, 2'b01, 3'd2, 4'd0);
    step();
    drive(1'b0, 2'b00, 3'd0, 4'd0);
    step();
    chk("sat_model", 32'(bus.model), 32'd2);
    force_val = 3'd3;
    force_en = 1'b1;
    step();
    chk("sat_first_mm", 32'(bus.mismatch), 32'd1);
    chk("sat_first_err", 32'(bus.err_count), 32'd1);
    for (int i = 0; i < 299; i++) step();
    chk("sat_mm_held", 32'(bus.mismatch), 32'd1);
    chk("sat_err", 32'(bus.err_count), 32'd255);
    force_en = 1'b0;
    step();
    chk("sat_mm_clear", 32'(bus.mismatch), 32'd0);
    chk("sat_err_hold", 32'(bus.err_count), 32'd255);

    // Reset in the fourth cycle of INC len 10
    drive(1'b1, 2'b10, 3'd0, 4'd10);
    step();
    drive(1'b0, 2'b00, 3'd0, 4'd0);
    chk("abort_inc_on", 32'(bus.inc), 32'd1);
    step();
    step();
    step();
    rst = 1'b1;
    #1;
    chk_reset_state("abort");
    force_val = 3'd5;
    force_en = 1'b1;
    step();
    rst = 1'b0;
    base_inc = inc_total;
    base_mm = mm_total;
    step();
    chk("post_rst_mm", 32'(bus.mismatch), 32'd0);
    force_en = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("post_rst_no_inc", 32'(inc_total - base_inc), 32'd0);
    chk("post_rst_no_mm", 32'(mm_total - base_mm), 32'd0);
    chk("post_rst_ready", 32'(bus.cmd_ready), 32'd1);
    chk("post_rst_err", 32'(bus.err_count), 32'd0);
    chk("post_rst_model", 32'(bus.model), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
